// File: rtl/fdga_mem_pkg.sv
// rtl/fdga_mem_pkg.sv - shared state encoding and defaults for the BRAM arbiter
package fdga_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port BRAM arbiter, data priority with fetch anti-starvation
module mem_arbiter
    import fdga_mem_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] i_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;

    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        state_d  = IDLE;
        starve_d = starve_q;

        if (!rst) begin
            if (i_req && (starve_q == LIMIT)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end

        if (i_gnt) begin
            state_d = I_RD;
        end else if (d_gnt) begin
            state_d = d_we ? D_WR : D_RD;
        end

        // Count only data wins that actually made fetch wait.
        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = i_gnt ? i_addr : (d_gnt ? d_addr : addr_q);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    // Gating with rst drops a read response that lands on a reset cycle.
    assign i_rvalid  = !rst && (state_q == I_RD);
    assign d_rvalid  = !rst && (state_q == D_RD);
    assign i_rdata   = i_rvalid ? mem_rdata : i_rdata_q;
    assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            addr_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (mem_en) begin
                addr_q <= mem_addr;
            end
            if (i_rvalid) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import fdga_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    logic [31:0] bram [0:255];

    mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at byte address a holds 0xA000_0000 + a.
    initial begin
        for (int k = 0; k < 256; k++) begin
            bram[k] = 32'hA000_0000 + 32'(k * 4);
        end
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                bram[mem_addr[9:2]] <= mem_wdata;
            end else begin
                mem_rdata <= bram[mem_addr[9:2]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h0; d_wdata = 32'h0;
        tick(); tick();
        checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got i=%b d=%b want 0 0", i_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem got en=%b we=%b want 0 0", mem_en, mem_we); end
        checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got i=%b d=%b want 0 0", i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got i=%h d=%h want 0 0", i_rdata, d_rdata); end
        checks++; if (dut.state_q !== IDLE || dut.starve_q !== 3'd0) begin failures++; $display("FAIL reset_state got st=%0d cnt=%0d want 0 0", dut.state_q, dut.starve_q); end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        i_req = 1'b1; i_addr = 32'h0; #1;
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1) begin failures++; $display("FAIL fetch_first_gnt got i=%b d=%b en=%b want 1 0 1", i_gnt, d_gnt, mem_en); end
        checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL fetch_mem_bus got a=%h we=%b wd=%h want 0 0 0", mem_addr, mem_we, mem_wdata); end
        tick(); i_addr = 32'h4; #1;
        checks++; if (i_gnt !== 1'b1 || i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0000) begin failures++; $display("FAIL fetch_word0 got g=%b v=%b d=%h want 1 1 a0000000", i_gnt, i_rvalid, i_rdata); end
        tick(); i_addr = 32'h8; #1;
        checks++; if (i_gnt !== 1'b1 || i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0004) begin failures++; $display("FAIL fetch_word1 got g=%b v=%b d=%h want 1 1 a0000004", i_gnt, i_rvalid, i_rdata); end
        tick(); i_req = 1'b0; i_addr = 32'h3C; #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0008) begin failures++; $display("FAIL fetch_word2 got v=%b d=%h want 1 a0000008", i_rvalid, i_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h8) begin failures++; $display("FAIL idle_addr_hold got en=%b a=%h want 0 00000008", mem_en, mem_addr); end
        tick();
        checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'hA000_0008) begin failures++; $display("FAIL fetch_rdata_hold got v=%b d=%h want 0 a0000008", i_rvalid, i_rdata); end
    endtask

    task automatic test_conflict();
        i_req = 1'b1; i_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
        checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 32'h100) begin failures++; $display("FAIL conflict_data_first got d=%b i=%b a=%h want 1 0 00000100", d_gnt, i_gnt, mem_addr); end
        tick(); d_req = 1'b0; #1;
        checks++; if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0100) begin failures++; $display("FAIL conflict_fetch_next got i=%b dv=%b dd=%h want 1 1 a0000100", i_gnt, d_rvalid, d_rdata); end
        tick(); i_req = 1'b0; #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_000C || d_rvalid !== 1'b0) begin failures++; $display("FAIL conflict_fetch_data got iv=%b id=%h dv=%b want 1 a000000c 0", i_rvalid, i_rdata, d_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_i;
        i_addr = 32'h10; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        for (int c = 1; c <= 10; c++) begin
            i_req = (c <= 5); d_req = 1'b1; #1;
            exp_i = (c == 5);
            checks++; if (i_gnt !== exp_i || d_gnt !== !exp_i || mem_we !== !exp_i) begin failures++; $display("FAIL starve_cycle%0d got i=%b d=%b we=%b want %b %b %b", c, i_gnt, d_gnt, mem_we, exp_i, !exp_i, !exp_i); end
            if (c == 6) begin
                checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0010) begin failures++; $display("FAIL starve_fetch_data got v=%b d=%h want 1 a0000010", i_rvalid, i_rdata); end
                checks++; if (dut.starve_q !== 3'd0) begin failures++; $display("FAIL starve_cleared got %0d want 0", dut.starve_q); end
            end
            tick();
        end
        d_req = 1'b0; d_we = 1'b0; i_req = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; #1;
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin failures++; $display("FAIL store_issue got g=%b we=%b wd=%h a=%h want 1 1 deadbeef 00000040", d_gnt, mem_we, mem_wdata, mem_addr); end
        tick(); d_we = 1'b0; #1;
        checks++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got v=%b g=%b we=%b want 0 1 0", d_rvalid, d_gnt, mem_we); end
        tick(); d_req = 1'b0; #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_after_store got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; i_req = 1'b1; i_addr = 32'h14;
        tick(); tick();
        d_req = 1'b0; d_we = 1'b0; #1;
        checks++; if (i_gnt !== 1'b1) begin failures++; $display("FAIL midread_gnt got %b want 1", i_gnt); end
        tick(); i_req = 1'b0; rst = 1'b1; #1;
        checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL midread_rvalid got %b want 0", i_rvalid); end
        tick(); rst = 1'b0; #1;
        checks++; if (i_rvalid !== 1'b0 || dut.state_q !== IDLE || dut.starve_q !== 3'd0) begin failures++; $display("FAIL midread_after got v=%b st=%0d cnt=%0d want 0 0 0", i_rvalid, dut.state_q, dut.starve_q); end
        tick();
    endtask

    task automatic test_withdrawal();
        i_req = 1'b1; i_addr = 32'h18; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = 32'h5555_AAAA;
        for (int c = 0; c < 4; c++) tick();
        #1;
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL withdraw_fetch_pri got i=%b d=%b we=%b want 1 0 0", i_gnt, d_gnt, mem_we); end
        tick(); d_req = 1'b0; i_req = 1'b0; #1;
        checks++; if (d_gnt !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL withdraw_no_access got d=%b we=%b en=%b want 0 0 0", d_gnt, mem_we, mem_en); end
        tick(); #1;
        checks++; if (dut.state_q !== IDLE || d_rvalid !== 1'b0) begin failures++; $display("FAIL withdraw_idle got st=%0d dv=%b want 0 0", dut.state_q, d_rvalid); end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_fetch_only();
        test_conflict();
        test_starvation();
        test_store_load();
        test_reset_mid_read();
        test_withdrawal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive data grants allowed while fetch waits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  fetch requester read request, held until i_gnt.
REQ-006 i_addr  input  WIDTH  fetch byte address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  i_rdata valid.
REQ-009 i_rdata  output  WIDTH  fetch read data.
REQ-010 d_req  input  1  data requester request, held until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load; sampled with d_req.
REQ-012 d_addr  input  WIDTH  data byte address.
REQ-013 d_wdata  input  WIDTH  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  d_rdata valid (loads only).
REQ-016 d_rdata  output  WIDTH  load data.
REQ-017 mem_en, mem_we  output  1 each  single-port BRAM enable and write enable.
REQ-018 mem_addr, mem_wdata  output  WIDTH each  BRAM address and write data.
REQ-019 mem_rdata  input  WIDTH  BRAM read data, valid exactly one cycle after a read-enabled cycle.

Function
REQ-020 The arbiter SHALL issue at most one BRAM access per cycle; the access issues in the same cycle as its grant (mem_en = i_gnt | d_gnt).
REQ-021 Only one grant SHALL be asserted in a cycle; a grant SHALL be asserted only while the corresponding req is high.
REQ-022 Default priority: data over fetch when both are requesting.
REQ-023 starve_cnt SHALL increment on each d_gnt while i_req is high and clear on i_gnt or when i_req is low; it SHALL saturate at STARVE_LIMIT.
REQ-024 When starve_cnt == STARVE_LIMIT and i_req is high, fetch SHALL win over data.
REQ-025 FSM states: IDLE, I_RD, D_RD, D_WR; the next state is set by the grant issued this cycle (fetch -> I_RD, load -> D_RD, store -> D_WR, none -> IDLE).
REQ-026 In I_RD: i_rvalid = 1 and i_rdata = mem_rdata. In D_RD: d_rvalid = 1 and d_rdata = mem_rdata. D_WR and IDLE: no rvalid.
REQ-027 A new grant SHALL be allowed in any state, giving back-to-back accesses with full throughput of one per cycle.
REQ-028 mem_we = d_gnt & d_we; mem_addr and mem_wdata come from the granted requester; mem_wdata = 0 and mem_we = 0 on fetch grants.
REQ-029 Read latency SHALL be exactly one cycle from grant to rvalid.
REQ-030 Store completion SHALL be signalled by d_gnt only.
REQ-031 When there is no grant, mem_en = 0 and mem_addr holds its last value; the inputs then have no effect.
REQ-032 If a requester drops req before its grant, no access SHALL issue and the state SHALL be otherwise unaffected.
REQ-033 i_rdata and d_rdata SHALL hold their last delivered value when rvalid is low.

Reset
REQ-034 While rst is high: state = IDLE, starve_cnt = 0, all grants, rvalids, mem_en and mem_we = 0, and rdata registers = 0.
REQ-035 A reset asserted in the cycle after a read grant SHALL suppress that rvalid.
REQ-036 The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-037 Shared package fdga_mem_pkg SHALL hold the FSM state enum (IDLE, I_RD, D_RD, D_WR) and the default STARVE_LIMIT constant.
REQ-038 The block is a single module with no sub-module; the starvation counter and FSM are inline.

Verification
REQ-039 Fetch only: i_req = 1 with i_addr 0x0, 0x4, 0x8 on consecutive cycles -> i_gnt every cycle, and i_rvalid with matching BRAM words one cycle later each.
REQ-040 Conflict: i_req and d_req both high, load to 0x100 -> d_gnt first, i_gnt next cycle; d_rvalid then i_rvalid on consecutive cycles.
REQ-041 Starvation: d_req stores held high for 10 cycles with i_req high and STARVE_LIMIT = 4 -> i_gnt on cycle 5; the counter clears, then data resumes winning.
REQ-042 Store then load: store 0xDEADBEEF to 0x40, then load from 0x40 -> no d_rvalid on the store, and d_rdata = 0xDEADBEEF one cycle after the load grant.
REQ-043 Reset mid-read: rst asserted the cycle after an i_gnt -> i_rvalid stays 0, state = IDLE, starve_cnt = 0.
REQ-044 Request withdrawal: d_req pulsed low before being granted while fetch holds priority -> no mem_we pulse and no d_gnt.
